// File: rtl/fp_alu_scheduler.sv
// fp_alu_scheduler: shares one combinational FP ALU between two requesters.
// Round-robin grant in IDLE, operands registered onto the ALU, a fixed settle
// countdown, then result/flags held in a response register until consumed.
// A saturating counter tracks how many responses carried any flag.
module fp_alu_scheduler #(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_n1,
  input  logic [31:0]      req0_n2,
  input  logic [1:0]       req0_oper,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_n1,
  input  logic [31:0]      req1_n2,
  input  logic [1:0]       req1_oper,
  output logic [31:0]      alu_n1,
  output logic [31:0]      alu_n2,
  output logic [1:0]       alu_oper,
  input  logic [31:0]      alu_result,
  input  logic             alu_overflow,
  input  logic             alu_underflow,
  input  logic             alu_exception,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_underflow,
  output logic             rsp_exception,
  output logic             busy,
  output logic [CNT_W-1:0] flag_count,
  input  logic             flag_count_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] n1;
    logic [31:0] n2;
    logic [1:0]  oper;
  } req_t;

  typedef struct packed {
    logic        id;
    logic [31:0] result;
    logic        ovf;
    logic        unf;
    logic        exc;
  } rsp_t;

  // Countdown preload: WAIT lasts LATENCY cycles including the capture cycle.
  localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

  state_t           state_q;
  req_t             alu_q;
  rsp_t             rsp_q;
  logic             rsp_valid_q;
  logic             last_q;
  logic [3:0]       cnt_q;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;

  req_t [1:0]       req;
  logic [1:0]       req_vld;
  logic [1:0]       req_rdy;
  logic             gnt_vld;
  logic             gnt_id;
  logic             capture;
  logic             cap_flag;

  assign req[0]  = {req0_n1, req0_n2, req0_oper};
  assign req[1]  = {req1_n1, req1_n2, req1_oper};
  assign req_vld = {req1_valid, req0_valid};

  // Round-robin: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    gnt_vld = |req_vld;
    gnt_id  = req_vld[1];
    if (&req_vld) gnt_id = ~last_q;
  end

  for (genvar i = 0; i < 2; i++) begin : g_rdy
    assign req_rdy[i] = (state_q == IDLE) && gnt_vld && (gnt_id == 1'(i));
  end

  assign req0_ready = req_rdy[0];
  assign req1_ready = req_rdy[1];

  assign capture  = (state_q == WAIT) && (cnt_q == 4'd0);
  assign cap_flag = alu_overflow | alu_underflow | alu_exception;

  // Sequencer: issue, settle countdown, capture, hold until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      alu_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            alu_q    <= req[gnt_id];
            rsp_q.id <= gnt_id;
            last_q   <= gnt_id;
            cnt_q    <= WAIT_LOAD;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            rsp_q.result <= alu_result;
            rsp_q.ovf    <= alu_overflow;
            rsp_q.unf    <= alu_underflow;
            rsp_q.exc    <= alu_exception;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          // Returning to IDLE here means the next grant waits a full cycle.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Flagged-result counter next state: clear beats increment, sticks at all-ones.
  always_comb begin
    fcnt_d = fcnt_q;
    if (flag_count_clr)
      fcnt_d = '0;
    else if (capture && cap_flag && (fcnt_q != '1))
      fcnt_d = fcnt_q + 1'b1;
  end

  // Flagged-result counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fcnt_q <= '0;
    else     fcnt_q <= fcnt_d;
  end

  assign alu_n1        = alu_q.n1;
  assign alu_n2        = alu_q.n2;
  assign alu_oper      = alu_q.oper;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_q.id;
  assign rsp_result    = rsp_q.result;
  assign rsp_overflow  = rsp_q.ovf;
  assign rsp_underflow = rsp_q.unf;
  assign rsp_exception = rsp_q.exc;
  assign busy          = (state_q != IDLE);
  assign flag_count    = fcnt_q;

endmodule

// File: tb/tb_fp_alu_scheduler.sv
// Bench for fp_alu_scheduler: a stand-in combinational ALU, a transaction-level
// model of grant order, response contents, latency and flag counting.
module tb_fp_alu_scheduler;

  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // Stand-in ALU: deterministic mix of operands; flags from simple operand rules.
  function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op);
    logic [31:0] r;
    logic ovf, unf, exc;
    r   = (a ^ {b[15:0], b[31:16]}) + {30'd0, op};
    ovf = (op == 2'd2) && a[30] && b[30];
    unf = (op == 2'd1) && (a == b);
    exc = (op == 2'd3) && (b[30:0] == 31'd0);
    return {ovf, unf, exc, r};
  endfunction

  // DUT with LATENCY=1
  logic        r0v, r0r, r1v, r1r;
  logic [31:0] r0n1, r0n2, r1n1, r1n2;
  logic [1:0]  r0op, r1op;
  logic [31:0] an1, an2, ares;
  logic [1:0]  aop;
  logic        aovf, aunf, aexc;
  logic        rv, rr, rid, rovf, runf, rexc, bsy, fclr;
  logic [31:0] rres;
  logic [7:0]  fcnt;

  assign {aovf, aunf, aexc, ares} = alu_f(an1, an2, aop);

  fp_alu_scheduler #(.LATENCY(LAT), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_ready(r0r), .req0_n1(r0n1), .req0_n2(r0n2), .req0_oper(r0op),
    .req1_valid(r1v), .req1_ready(r1r), .req1_n1(r1n1), .req1_n2(r1n2), .req1_oper(r1op),
    .alu_n1(an1), .alu_n2(an2), .alu_oper(aop),
    .alu_result(ares), .alu_overflow(aovf), .alu_underflow(aunf), .alu_exception(aexc),
    .rsp_valid(rv), .rsp_ready(rr), .rsp_id(rid), .rsp_result(rres),
    .rsp_overflow(rovf), .rsp_underflow(runf), .rsp_exception(rexc),
    .busy(bsy), .flag_count(fcnt), .flag_count_clr(fclr)
  );

  // DUT with LATENCY=4
  logic        q0v, q0r, q1v, q1r;
  logic [31:0] q0n1, q0n2, q1n1, q1n2;
  logic [1:0]  q0op, q1op;
  logic [31:0] qan1, qan2, qares;
  logic [1:0]  qaop;
  logic        qaovf, qaunf, qaexc;
  logic        qrv, qrr, qrid, qrovf, qrunf, qrexc, qbsy, qfclr;
  logic [31:0] qrres;
  logic [7:0]  qfcnt;

  assign {qaovf, qaunf, qaexc, qares} = alu_f(qan1, qan2, qaop);

  fp_alu_scheduler #(.LATENCY(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(q0v), .req0_ready(q0r), .req0_n1(q0n1), .req0_n2(q0n2), .req0_oper(q0op),
    .req1_valid(q1v), .req1_ready(q1r), .req1_n1(q1n1), .req1_n2(q1n2), .req1_oper(q1op),
    .alu_n1(qan1), .alu_n2(qan2), .alu_oper(qaop),
    .alu_result(qares), .alu_overflow(qaovf), .alu_underflow(qaunf), .alu_exception(qaexc),
    .rsp_valid(qrv), .rsp_ready(qrr), .rsp_id(qrid), .rsp_result(qrres),
    .rsp_overflow(qrovf), .rsp_underflow(qrunf), .rsp_exception(qrexc),
    .busy(qbsy), .flag_count(qfcnt), .flag_count_clr(qfclr)
  );

  // Model state: pending requests, last grant, expected flag count.
  logic [31:0] mn1 [2];
  logic [31:0] mn2 [2];
  logic [1:0]  mop [2];
  bit          mv  [2];
  int          m_last;
  int          m_fcnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    r0v = mv[0]; r0n1 = mn1[0]; r0n2 = mn2[0]; r0op = mop[0];
    r1v = mv[1]; r1n1 = mn1[1]; r1n2 = mn2[1]; r1op = mop[1];
  endtask

  // One full transaction on the LATENCY=1 DUT; bp = cycles of backpressure,
  // clr_cap = pulse flag_count_clr on the capture edge, refill = granted
  // requester stays valid with the next opcode (opcode+2) and new operands.
  task automatic transact(input int bp, input bit clr_cap, input bit refill);
    int          g;
    int          edges;
    logic [34:0] exp;
    logic [31:0] gn1, gn2;
    logic [1:0]  gop;
    apply();
    #1;
    if (mv[0] && mv[1]) g = 1 - m_last;
    else if (mv[1])     g = 1;
    else                g = 0;
    chk("req0_ready_idle", r0r, g == 0);
    chk("req1_ready_idle", r1r, g == 1);
    gn1 = mn1[g]; gn2 = mn2[g]; gop = mop[g];
    exp = alu_f(gn1, gn2, gop);
    @(posedge clk); #1;
    m_last = g;
    if (refill) begin
      mn1[g] = $urandom; mn2[g] = $urandom; mop[g] = gop + 2'd2;
    end else begin
      mv[g] = 1'b0;
    end
    apply();
    chk("alu_n1", an1, gn1);
    chk("alu_n2", an2, gn2);
    chk("alu_oper", aop, gop);
    edges = 1;
    while (rv !== 1'b1 && edges < 40) begin
      chk("busy_wait", bsy, 1'b1);
      chk("ready_wait", {r0r, r1r}, 2'b00);
      if (clr_cap && edges == LAT) fclr = 1'b1;
      @(posedge clk); #1;
      fclr = 1'b0;
      edges++;
      chk("alu_stable", {an1, an2, aop}, {gn1, gn2, gop});
    end
    chk("latency", edges, LAT + 1);
    if (exp[34:32] != 3'b000 && m_fcnt < 255) m_fcnt++;
    if (clr_cap) m_fcnt = 0;
    chk("rsp_id", rid, g);
    chk("rsp_result", rres, exp[31:0]);
    chk("rsp_flags", {rovf, runf, rexc}, exp[34:32]);
    chk("flag_count", fcnt, m_fcnt);
    repeat (bp) begin
      @(posedge clk); #1;
      chk("bp_valid", rv, 1'b1);
      chk("bp_fields", {rid, rres, rovf, runf, rexc}, {g[0], exp[31:0], exp[34:32]});
      chk("bp_ready", {r0r, r1r}, 2'b00);
      chk("bp_busy", bsy, 1'b1);
    end
    rr = 1'b1;
    #1;
    chk("resp_ready_block", {r0r, r1r}, 2'b00);
    @(posedge clk); #1;
    rr = 1'b0;
    chk("rsp_valid_drop", rv, 1'b0);
    chk("busy_idle", bsy, 1'b0);
  endtask

  int          edges4;
  logic [34:0] exp4;

  initial begin
    rst = 1'b1; rr = 1'b0; fclr = 1'b0;
    qrr = 1'b0; qfclr = 1'b0; q0v = 1'b0; q1v = 1'b0;
    q0n1 = '0; q0n2 = '0; q0op = '0; q1n1 = '0; q1n2 = '0; q1op = '0;
    for (int j = 0; j < 2; j++) begin mv[j] = 0; mn1[j] = '0; mn2[j] = '0; mop[j] = '0; end
    apply();
    m_last = 1; m_fcnt = 0;
    #12;
    chk("rst_alu", {an1, an2, aop}, 66'd0);
    chk("rst_rsp", {rv, rid, rres, rovf, runf, rexc}, 37'd0);
    chk("rst_busy", bsy, 1'b0);
    chk("rst_fcnt", fcnt, 8'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_req", {r0r, r1r}, 2'b00);

    // Round-robin: both held valid over four ops, opcodes 0..3.
    mv[0] = 1; mv[1] = 1;
    mn1[0] = $urandom; mn2[0] = $urandom; mop[0] = 2'd0;
    mn1[1] = $urandom; mn2[1] = $urandom; mop[1] = 2'd1;
    for (int k = 0; k < 4; k++) transact(0, 0, (k < 2));
    mv[0] = 0; mv[1] = 0;

    // Single op with known operands.
    mv[0] = 1; mn1[0] = 32'h4236B000; mn2[0] = 32'h41BC7000; mop[0] = 2'd0;
    transact(0, 0, 0);

    // Backpressure: five cycles held.
    mv[1] = 1; mn1[1] = $urandom; mn2[1] = $urandom; mop[1] = 2'd2;
    transact(5, 0, 0);

    // Divide by zero flags, then clear coinciding with a flagged capture.
    mv[0] = 1; mn1[0] = 32'h4236B000; mn2[0] = 32'h00000000; mop[0] = 2'd3;
    transact(0, 0, 0);
    mv[0] = 1;
    transact(0, 1, 0);

    // Saturation of the flag counter.
    for (int k = 0; k < 258; k++) begin
      mv[k % 2] = 1; mn1[k % 2] = $urandom; mn2[k % 2] = 32'h80000000; mop[k % 2] = 2'd3;
      transact(0, 0, 0);
    end
    chk("fcnt_sat", fcnt, 8'hFF);
    fclr = 1'b1;
    @(posedge clk); #1;
    fclr = 1'b0; m_fcnt = 0;
    chk("fcnt_clr", fcnt, 8'd0);

    // LATENCY=4 instance.
    q0v = 1'b1; q0n1 = $urandom; q0n2 = $urandom; q0op = 2'($urandom_range(0, 3));
    #1;
    chk("l4_ready", {q0r, q1r}, 2'b10);
    exp4 = alu_f(q0n1, q0n2, q0op);
    @(posedge clk); #1;
    q0v = 1'b0;
    chk("l4_alu", {qan1, qan2, qaop}, {q0n1, q0n2, q0op});
    edges4 = 1;
    while (qrv !== 1'b1 && edges4 < 40) begin
      chk("l4_busy", qbsy, 1'b1);
      @(posedge clk); #1;
      edges4++;
      chk("l4_alu_stable", {qan1, qan2, qaop}, {q0n1, q0n2, q0op});
    end
    chk("l4_latency", edges4, 5);
    chk("l4_result", {qrid, qrres, qrovf, qrunf, qrexc}, {1'b0, exp4[31:0], exp4[34:32]});
    qrr = 1'b1;
    @(posedge clk); #1;
    qrr = 1'b0;
    chk("l4_done", {qrv, qbsy}, 2'b00);

    // Randomised traffic; a waiting requester holds its request.
    for (int k = 0; k < 24; k++) begin
      for (int j = 0; j < 2; j++) begin
        if (!mv[j] && $urandom_range(0, 1) == 1) begin
          mv[j] = 1; mn1[j] = $urandom; mop[j] = 2'($urandom_range(0, 3));
          mn2[j] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        end
      end
      if (!mv[0] && !mv[1]) begin
        mv[0] = 1; mn1[0] = $urandom; mn2[0] = $urandom; mop[0] = 2'($urandom_range(0, 3));
      end
      transact($urandom_range(0, 3), 0, 0);
    end
    mv[0] = 0; mv[1] = 0;

    // Reset in WAIT after a flagged op leaves the counter non-zero.
    mv[0] = 1; mn1[0] = $urandom; mn2[0] = 32'h0; mop[0] = 2'd3;
    transact(0, 0, 0);
    mv[1] = 1; mn1[1] = $urandom; mn2[1] = $urandom; mop[1] = 2'd1;
    apply();
    @(posedge clk); #1;
    mv[1] = 0; apply();
    chk("pre_rst_busy", bsy, 1'b1);
    rst = 1'b1;
    #2;
    chk("midrst_rsp", rv, 1'b0);
    chk("midrst_fcnt", fcnt, 8'd0);
    chk("midrst_alu", {an1, an2, aop}, 66'd0);
    chk("midrst_busy", bsy, 1'b0);
    rst = 1'b0;
    m_last = 1; m_fcnt = 0;
    mv[0] = 1; mv[1] = 1;
    mn1[0] = $urandom; mn2[0] = $urandom; mop[0] = 2'd0;
    mn1[1] = $urandom; mn2[1] = $urandom; mop[1] = 2'd0;
    apply();
    #1;
    chk("post_rst_tie", {r0r, r1r}, 2'b10);
    transact(0, 0, 0);
    transact(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
